// File: rtl/johnson_phase_monitor_pkg.sv
// Shared types and the Johnson code table for the phase monitor and its decoder.
package johnson_pkg;

    localparam int JOHNSON_PHASES = 8;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_TRACK = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

    // Index i holds the 4-bit Johnson code for phase i.
    localparam logic [3:0] JOHNSON_SEQ [JOHNSON_PHASES] = '{
        4'b0000, 4'b1000, 4'b1100, 4'b1110,
        4'b1111, 4'b0111, 4'b0011, 4'b0001
    };

    function automatic logic [JOHNSON_PHASES-1:0] phase_to_onehot(input logic [2:0] idx);
        return JOHNSON_PHASES'(1) << idx;
    endfunction

endpackage

// File: rtl/johnson_phase_monitor_if.sv
// Count-bus input and decoded phase/status outputs of the Johnson phase monitor.
interface johnson_phase_monitor_if #(
    parameter int REV_W = 8,
    parameter int ERR_W = 4
);
    logic             sample_en;
    logic [3:0]       count_in;
    logic [7:0]       phase_onehot;
    logic [2:0]       phase_idx;
    logic             phase_valid;
    logic             illegal_code;
    logic             seq_error;
    logic             stall;
    logic [REV_W-1:0] rev_count;
    logic             rev_wrap;
    logic [ERR_W-1:0] err_count;

    modport master (
        output sample_en, count_in,
        input  phase_onehot, phase_idx, phase_valid, illegal_code, seq_error,
               stall, rev_count, rev_wrap, err_count
    );

    modport slave (
        input  sample_en, count_in,
        output phase_onehot, phase_idx, phase_valid, illegal_code, seq_error,
               stall, rev_count, rev_wrap, err_count
    );
endinterface

// File: rtl/johnson_phase_monitor_decode.sv
// Combinational Johnson code decoder: table lookup to phase index plus legality flag.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [2:0] idx_o,
    output logic       legal_o
);
    always_comb begin
        idx_o   = '0;
        legal_o = 1'b0;
        for (int i = 0; i < JOHNSON_PHASES; i++) begin
            if (code_i == JOHNSON_SEQ[i]) begin
                idx_o   = 3'(i);
                legal_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks a Johnson count bus: phase decode, sequence/legality checking,
// stall detection, revolution and error counting. All outputs registered.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int REV_W     = 8,
    parameter int ERR_W     = 4,
    parameter int STALL_MAX = 16
) (
    input  logic                    clk,
    input  logic                    clear,
    johnson_phase_monitor_if.slave  mon
);
    localparam int HOLD_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STALL_MAX);

    logic [2:0] dec_idx;
    logic       dec_legal;

    johnson_decode u_decode (
        .code_i  (mon.count_in),
        .idx_o   (dec_idx),
        .legal_o (dec_legal)
    );

    mon_state_t        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              stall_q, stall_d;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic              wrap_q, wrap_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              ill_q, ill_d;
    logic              seq_q, seq_d;
    logic [2:0]        idx_succ;

    assign idx_succ = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        stall_d = stall_q;
        rev_d   = rev_q;
        err_d   = err_q;
        wrap_d  = 1'b0;
        ill_d   = 1'b0;
        seq_d   = 1'b0;
        if (mon.sample_en) begin
            case (state_q)
                MON_IDLE, MON_FAULT: begin
                    if (dec_legal) begin
                        state_d = MON_TRACK;
                        idx_d   = dec_idx;
                        hold_d  = '0;
                        stall_d = 1'b0;
                    end else begin
                        state_d = MON_FAULT;
                        ill_d   = 1'b1;
                    end
                end
                MON_TRACK: begin
                    if (!dec_legal) begin
                        state_d = MON_FAULT;
                        ill_d   = 1'b1;
                        hold_d  = '0;
                        stall_d = 1'b0;
                    end else if (dec_idx == idx_q) begin
                        // Hold count saturates so stall stays asserted for long holds.
                        if (STALL_MAX > 0) begin
                            if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
                            stall_d = (hold_d == HOLD_MAX);
                        end
                    end else if (dec_idx == idx_succ) begin
                        idx_d   = dec_idx;
                        hold_d  = '0;
                        stall_d = 1'b0;
                        if (idx_q == 3'd7) begin
                            rev_d  = rev_q + REV_W'(1);
                            wrap_d = (rev_q == '1);
                        end
                    end else begin
                        seq_d   = 1'b1;
                        idx_d   = dec_idx;
                        hold_d  = '0;
                        stall_d = 1'b0;
                    end
                end
                default: state_d = MON_IDLE;
            endcase
            if ((ill_d || seq_d) && (err_q != '1)) err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= MON_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            stall_q <= 1'b0;
            rev_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= '0;
            ill_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            stall_q <= stall_d;
            rev_q   <= rev_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            ill_q   <= ill_d;
            seq_q   <= seq_d;
        end
    end

    assign mon.phase_valid  = (state_q == MON_TRACK);
    assign mon.phase_onehot = (state_q == MON_TRACK) ? phase_to_onehot(idx_q) : '0;
    assign mon.phase_idx    = idx_q;
    assign mon.illegal_code = ill_q;
    assign mon.seq_error    = seq_q;
    assign mon.stall        = stall_q;
    assign mon.rev_count    = rev_q;
    assign mon.rev_wrap     = wrap_q;
    assign mon.err_count    = err_q;

endmodule
